// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder and the CPU memory interface:
// the responder FSM state encoding and the data/address widths of the port.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage : mem_responder_pkg

// File: rtl/sync_word_ram.sv
// -----------------------------------------------------------------------------
// sync_word_ram
// Word-organised storage, 2^ADDR_BITS words of DATA_BITS bits, one clock.
// Ports:
//   i_clk    clock, all updates on the rising edge
//   i_rst    async active-high reset of the read data register only
//   i_addr   word address shared by the write and read ports
//   i_we     write enable, i_wdata written to i_addr
//   i_re     read enable, storage word at i_addr loaded into o_rdata
//   i_clr    synchronous clear of o_rdata (wins over i_re)
//   o_rdata  registered read data, held while neither i_re nor i_clr
// The storage array itself is never reset, so contents survive a reset.
// -----------------------------------------------------------------------------
module sync_word_ram #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic                 i_we,
   input  logic [DATA_BITS-1:0] i_wdata,
   input  logic                 i_re,
   input  logic                 i_clr,
   output logic [DATA_BITS-1:0] o_rdata
);

   logic [DATA_BITS-1:0] r_mem [0:(1<<ADDR_BITS)-1];
   logic [DATA_BITS-1:0] r_rdata;

   // Storage write port; deliberately no reset so contents persist.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Read data register: cleared on reset/clear, loaded on read enable.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_clr) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule : sync_word_ram

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Target end of the 16-bit CPU memory port. Accepts one request at a time,
// waits WAIT_CYCLES states, commits/reads storage on entry to RESP and holds
// the response until the requester takes it.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake
//   req_write, req_addr,     request kind (1 = write), byte address,
//   req_wdata                write data
//   resp_valid/resp_ready    response handshake
//   resp_rdata               read data (0 for writes and errors)
//   resp_err                 misaligned or out-of-range access
// -----------------------------------------------------------------------------
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int WORD_ADDR_BITS = 8,
   parameter int WAIT_CYCLES    = 2,
   parameter int CNT_WIDTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err
);

   localparam bit NO_WAIT = (WAIT_CYCLES == 0);

   state_e                r_state;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_req_ready;
   logic                  r_resp_valid;
   logic                  r_resp_err;

   logic                  w_enter;
   logic                  w_write;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_range_err;
   logic                  w_err;

   // Access seen at RESP entry: live request when going straight from IDLE
   // (zero wait states), otherwise the captured request.
   always_comb begin
      w_enter = 1'b0;
      w_write = r_write;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      case (r_state)
         IDLE: begin
            w_write = req_write;
            w_addr  = req_addr;
            w_wdata = req_wdata;
            w_enter = req_valid & NO_WAIT;
         end
         WAIT: begin
            w_enter = (r_cnt == CNT_WIDTH'(1));
         end
         default: begin
            w_enter = 1'b0;
         end
      endcase
   end

   // Address bits above the storage window must be zero.
   generate
      if (WORD_ADDR_BITS < 15) begin : g_range
         assign w_range_err = |w_addr[ADDR_WIDTH-1:WORD_ADDR_BITS+1];
      end else begin : g_full
         assign w_range_err = 1'b0;
      end
   endgenerate

   assign w_err = w_addr[0] | w_range_err;

   sync_word_ram #(
      .ADDR_BITS (WORD_ADDR_BITS),
      .DATA_BITS (DATA_WIDTH)
   ) u_ram (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_addr  (w_addr[WORD_ADDR_BITS:1]),
      .i_we    (w_enter & w_write & ~w_err),
      .i_wdata (w_wdata),
      .i_re    (w_enter & ~w_write & ~w_err),
      // Read data must read 0 for writes/errors and after the handshake.
      .i_clr   ((w_enter & (w_write | w_err)) | ((r_state == RESP) & resp_ready)),
      .o_rdata (resp_rdata)
   );

   // Request/response FSM with wait-state counter and registered handshakes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_write     <= req_write;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (NO_WAIT) begin
                     r_state      <= RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= w_err;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= CNT_WIDTH'(WAIT_CYCLES);
                  end
               end
            end
            WAIT: begin
               if (r_cnt == CNT_WIDTH'(1)) begin
                  r_state      <= RESP;
                  r_cnt        <= '0;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= w_err;
               end else begin
                  r_cnt <= r_cnt - CNT_WIDTH'(1);
               end
            end
            RESP: begin
               // Ready is raised only after the handshake edge, so no request
               // can be accepted in the cycle a response completes.
               if (resp_ready) begin
                  r_state      <= IDLE;
                  r_req_ready  <= 1'b1;
                  r_resp_valid <= 1'b0;
                  r_resp_err   <= 1'b0;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_cnt        <= '0;
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;

endmodule : mem_responder
